// File: rtl/alu_wb_queue.sv
// In-order result queue between the integer ALU and the scoreboard writeback port.
// Optional same-cycle bypass of an empty queue is enabled by defining ALU_WB_BYPASS_EN.
module alu_wb_queue #(
  parameter int XLEN          = 64,
  parameter int DEPTH         = 4,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         alu_valid_i,
  output logic                         alu_ready_o,
  input  logic [XLEN-1:0]              alu_result_i,
  input  logic [TRANS_ID_BITS-1:0]     alu_trans_id_i,
  input  logic                         alu_branch_res_i,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  output logic [XLEN-1:0]              wb_result_o,
  output logic [TRANS_ID_BITS-1:0]     wb_trans_id_o,
  output logic                         wb_branch_res_o,
  output logic [$clog2(DEPTH):0]       usage_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]          result_q   [DEPTH];
  logic [TRANS_ID_BITS-1:0] trans_id_q [DEPTH];
  logic [DEPTH-1:0]         branch_q;

  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign usage_o = count_q;

  // Ready comes from the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign alu_ready_o = !full;

`ifdef ALU_WB_BYPASS_EN
  logic bypass;
  logic bypass_taken;

  assign bypass       = empty && alu_valid_i && !flush_i;
  assign bypass_taken = bypass && wb_ready_i;

  assign wb_valid_o      = !empty || bypass;
  assign wb_result_o     = bypass ? alu_result_i     : result_q[rd_ptr_q];
  assign wb_trans_id_o   = bypass ? alu_trans_id_i   : trans_id_q[rd_ptr_q];
  assign wb_branch_res_o = bypass ? alu_branch_res_i : branch_q[rd_ptr_q];

  // A bypassed result that the port accepts is never stored.
  assign push = alu_valid_i && alu_ready_o && !bypass_taken;
  assign pop  = !empty && wb_ready_i;
`else
  assign wb_valid_o      = !empty;
  assign wb_result_o     = result_q[rd_ptr_q];
  assign wb_trans_id_o   = trans_id_q[rd_ptr_q];
  assign wb_branch_res_o = branch_q[rd_ptr_q];

  assign push = alu_valid_i && alu_ready_o;
  assign pop  = wb_valid_o && wb_ready_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      branch_q <= '0;
      // NOTE: storage is cleared on reset so the head data reads as zero
      // afterwards; this costs a reset mux on every storage bit.
      for (int i = 0; i < DEPTH; i++) begin
        result_q[i]   <= '0;
        trans_id_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        result_q[wr_ptr_q]   <= alu_result_i;
        trans_id_q[wr_ptr_q] <= alu_trans_id_i;
        branch_q[wr_ptr_q]   <= alu_branch_res_i;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/alu_wb_queue.md
# alu_wb_queue

Result-side consumer of the integer ALU. It captures each ALU result (value, transaction ID, branch outcome) into a small in-order queue and presents it to the writeback/commit port with a valid/ready handshake. This decouples the single-cycle ALU from writeback-port stalls and absorbs back-to-back results while the port is busy. It sits between the ALU output and the scoreboard writeback bus.

## Interface
Parameters:
- XLEN, 64, datapath width; 32 or 64
- DEPTH, 4, queue entries; power of two, >= 2
- TRANS_ID_BITS, 3, width of scoreboard transaction ID

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset; synchronous, active-low
- flush_i  in  1  discard all queued entries
- alu_valid_i  in  1  ALU result valid
- alu_ready_o  out  1  queue can accept a result
- alu_result_i  in  XLEN  ALU result value
- alu_trans_id_i  in  TRANS_ID_BITS  transaction ID of result
- alu_branch_res_i  in  1  branch comparison outcome
- wb_valid_o  out  1  head entry valid
- wb_ready_i  in  1  writeback port accepts head
- wb_result_o  out  XLEN  head result
- wb_trans_id_o  out  TRANS_ID_BITS  head transaction ID
- wb_branch_res_o  out  1  head branch outcome
- usage_o  out  $clog2(DEPTH)+1  number of stored entries

## Operation
- Storage: DEPTH-entry circular buffer, read pointer, write pointer, and count; pointers $clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- Push: alu_valid_i && alu_ready_o. The entry is written at the write pointer, and the write pointer is incremented.
- Pop: wb_valid_o && wb_ready_i. The read pointer is incremented.
- alu_ready_o = (count != DEPTH). It depends on registered state only, with no combinational path from wb_ready_i.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full (count == DEPTH): alu_ready_o = 0. A pop in the same cycle does not enable a push; the push is accepted the next cycle.
- Empty (count == 0): wb_valid_o = 0 unless bypass is active (see Configuration). wb_* data outputs are don't-care when wb_valid_o = 0.
- Ordering: strictly FIFO; results leave in acceptance order.
- flush_i: synchronous. Next cycle count = 0, pointers = 0, wb_valid_o = 0. It overrides a push or pop in the same cycle; the flushed-cycle input is dropped.
- Reset (rst_ni = 0 at edge): pointers, count, and all storage cleared to 0. Outputs after reset: wb_valid_o = 0, wb_result_o = 0, wb_trans_id_o = 0, wb_branch_res_o = 0, usage_o = 0, alu_ready_o = 1. Reset mid-operation discards all entries, including one being pushed.
- Held valid: if wb_ready_i = 0, wb_* outputs are held stable until popped.

## Timing
- Base latency: result pushed at edge N appears on wb_* at cycle N+1 (registered path).
- Throughput: 1 push and 1 pop per cycle sustained when not full.
- usage_o reflects registered count (post-edge value).
- Back-pressure: with wb_ready_i = 0 for DEPTH consecutive pushes, alu_ready_o falls in the cycle after the DEPTH-th push.

## Configuration
- ALU_WB_BYPASS_EN defined: when count == 0 and alu_valid_i = 1, wb_valid_o = 1 in the same cycle, and wb_* are driven combinationally from alu_* inputs.
  - If wb_ready_i = 1 in that cycle, the entry is consumed and not stored; count stays 0 (zero latency).
  - If wb_ready_i = 0, the entry is stored normally and presented from storage next cycle.
  - flush_i suppresses bypass: wb_valid_o = 0 in that cycle.
- ALU_WB_BYPASS_EN undefined: no input-to-output combinational path; minimum latency is 1 cycle.

## Test plan
- Reset, then idle: wb_valid_o = 0, usage_o = 0, alu_ready_o = 1, wb_result_o = 0.
- Push result 0xDEAD_BEEF, ID 5, branch 1, with wb_ready_i = 1 (no bypass): wb_valid_o = 1 next cycle with 0xDEAD_BEEF/5/1; usage_o returns to 0 after pop.
- DEPTH = 4, wb_ready_i = 0, push IDs 0..4 on consecutive cycles:
  - alu_ready_o = 0 after the 4th push, and ID 4 is held off.
  - Raising wb_ready_i pops IDs 0,1,2,3 in order; ID 4 is accepted one cycle after the first pop.
- Full queue with simultaneous push attempt and pop: count drops to 3 and the push is not accepted; next cycle it is accepted and count returns to 4.
- Three entries queued, flush_i asserted with alu_valid_i = 1: next cycle usage_o = 0 and wb_valid_o = 0; the flush-cycle input never appears on wb_*.
- With ALU_WB_BYPASS_EN defined, empty queue, push 0x1234 with wb_ready_i = 1: wb_valid_o = 1 and wb_result_o = 0x1234 in the same cycle; usage_o stays 0.
